// File: rtl/i2c_slave_regfile.sv
// I2C target exposing NUM_REGS 8-bit registers behind an auto-incrementing pointer.
// Bus lines are oversampled on clk; a host-side port reads registers and observes writes.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR  = 7'b1001011,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        AW          = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  input  logic [AW-1:0] host_rd_addr,
  output logic [7:0]    host_rd_data,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK, WAIT_STOP
  } state_t;

  state_t                      state;
  logic [SYNC_STAGES-1:0]      scl_sync, sda_sync;
  logic                        scl_d, sda_d, scl_s, sda_s;
  logic                        scl_rise, scl_fall, start_det, stop_det;
  logic [3:0]                  cnt;
  logic [7:0]                  sr, tx, byte_nxt;
  logic                        rw;
  logic [AW-1:0]               ptr;
  logic [NUM_REGS-1:0][7:0]    regs;

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  // SCL must be high on both sides of the SDA transition
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign byte_nxt  = {sr[6:0], sda_s};

  assign host_rd_data = regs[host_rd_addr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      ptr       <= '0;
      regs      <= '0;
      cnt       <= '0;
      sr        <= '0;
      tx        <= '0;
      rw        <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (start_det) begin
        state  <= ADDR;
        cnt    <= '0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        cnt    <= '0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            sr  <= byte_nxt;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt <= '0;
              if (byte_nxt[7:1] == SLAVE_ADDR && byte_nxt[7:1] != 7'h00) begin
                state <= ADDR_ACK;
                busy  <= 1'b1;
                rw    <= byte_nxt[0];
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          PTR: if (scl_rise) begin
            sr  <= byte_nxt;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt <= '0;
              if ({1'b0, byte_nxt} < 9'(NUM_REGS)) begin
                ptr   <= byte_nxt[AW-1:0];
                state <= PTR_ACK;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          WDATA: if (scl_rise) begin
            sr  <= byte_nxt;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt       <= '0;
              regs[ptr] <= byte_nxt;
              wr_strobe <= 1'b1;
              wr_addr   <= ptr;
              wr_data   <= byte_nxt;
              state     <= WACK;
            end
          end
          // cnt = 0: waiting for the fall that opens the 9th clock; 1: holding ACK
          ADDR_ACK, PTR_ACK, WACK: if (scl_fall) begin
            if (cnt == 4'd0) begin
              sda_oe <= 1'b1;
              cnt    <= 4'd1;
            end else begin
              cnt <= '0;
              case (state)
                ADDR_ACK: if (rw) begin
                  state  <= RDATA;
                  tx     <= regs[ptr];
                  sda_oe <= ~regs[ptr][7];
                end else begin
                  state  <= PTR;
                  sda_oe <= 1'b0;
                end
                PTR_ACK: begin
                  state  <= WDATA;
                  sda_oe <= 1'b0;
                end
                default: begin
                  state  <= WDATA;
                  sda_oe <= 1'b0;
                  ptr    <= ptr + AW'(1);
                end
              endcase
            end
          end
          RDATA: begin
            if (scl_rise) cnt <= cnt + 4'd1;
            if (scl_fall) begin
              if (cnt == 4'd8) begin
                sda_oe <= 1'b0;
                cnt    <= '0;
                state  <= RACK;
              end else begin
                tx     <= {tx[6:0], 1'b0};
                sda_oe <= ~tx[6];
              end
            end
          end
          RACK: begin
            if (scl_rise) begin
              if (sda_s) state <= WAIT_STOP;
              else begin
                cnt <= 4'd1;
                ptr <= ptr + AW'(1);
              end
            end
            if (scl_fall && cnt == 4'd1) begin
              cnt    <= '0;
              tx     <= regs[ptr];
              sda_oe <= ~regs[ptr][7];
              state  <= RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged I2C master, register-file reference model,
// and a scoreboard monitor that checks ACKs, read bytes and write strobes.
module tb_i2c_slave_regfile;
  localparam logic [6:0] SA = 7'h4B;
  localparam int NR = 16;
  localparam int AW = 4;
  localparam int Q  = 5;

  logic          clk, reset, scl_m, sda_m, sda_bus;
  logic          sda_oe, wr_strobe, busy;
  logic [AW-1:0] host_rd_addr, wr_addr;
  logic [7:0]    host_rd_data, wr_data;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_regfile #(.SLAVE_ADDR(SA), .NUM_REGS(NR), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_bus), .sda_oe(sda_oe),
    .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int oe_cnt = 0;
  always @(posedge clk) if (sda_oe) oe_cnt <= oe_cnt + 1;

  int n_cmp = 0, n_bad = 0;
  logic [8:0]    exp_bus[$], obs_q[$];   // {is_ack, value}
  logic [AW+7:0] exp_wr[$];
  logic [7:0]    mregs [NR];
  int            mptr;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    logic [8:0] o, e;
    logic [AW+7:0] w;
    forever begin
      @(negedge clk);
      if (reset && wr_strobe) begin
        n_cmp++;
        if (exp_wr.size() == 0) begin
          n_bad++;
          $display("FAIL wr_strobe: got (%0d,%h) but no write expected", wr_addr, wr_data);
        end else begin
          w = exp_wr.pop_front();
          if ({wr_addr, wr_data} !== w) begin
            n_bad++;
            $display("FAIL wr_strobe: got (%0d,%h) expected (%0d,%h)", wr_addr, wr_data, w[AW+7:8], w[7:0]);
          end
        end
      end
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        n_cmp++;
        if (exp_bus.size() == 0) begin
          n_bad++;
          $display("FAIL bus_resp: got %h but nothing expected", o);
        end else begin
          e = exp_bus.pop_front();
          if (o !== e) begin
            n_bad++;
            $display("FAIL bus_resp %s: got %h expected %h", e[8] ? "ack" : "rdata", o[7:0], e[7:0]);
          end
        end
      end
    end
  endtask

  task automatic wq(); repeat (Q) @(negedge clk); endtask
  task automatic bus_start(); sda_m = 1; wq(); scl_m = 1; wq(); sda_m = 0; wq(); scl_m = 0; wq(); endtask
  task automatic bus_stop();  sda_m = 0; wq(); scl_m = 1; wq(); sda_m = 1; wq(); endtask
  task automatic bus_bit(input logic b, output logic s);
    sda_m = b; wq(); scl_m = 1; wq(); s = sda_bus; wq(); scl_m = 0; wq();
  endtask

  task automatic write_byte(input logic [7:0] d, input logic exp_ack);
    logic s;
    exp_bus.push_back({1'b1, 7'b0, exp_ack});
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, s);
    obs_q.push_back({1'b1, 7'b0, ~s});
  endtask

  task automatic read_byte(input logic ack);
    logic s;
    logic [7:0] d = '0;
    exp_bus.push_back({1'b0, mregs[mptr]});
    for (int i = 0; i < 8; i++) begin bus_bit(1'b1, s); d = {d[6:0], s}; end
    bus_bit(~ack, s);
    obs_q.push_back({1'b0, d});
    if (ack) mptr = (mptr + 1) % NR;
  endtask

  // Write transaction: address a, pointer byte p, then n data bytes taken from dat LSB-first.
  task automatic txn_write(input logic [6:0] a, input logic [7:0] p, input int n, input logic [31:0] dat);
    bit hit = (a == SA) && (a != 7'h00);
    logic [7:0] d;
    bus_start();
    write_byte({a, 1'b0}, hit);
    if (!hit) begin write_byte(p, 1'b0); bus_stop(); return; end
    write_byte(p, int'(p) < NR);
    if (int'(p) >= NR) begin bus_stop(); return; end
    mptr = int'(p);
    for (int i = 0; i < n; i++) begin
      d = dat[8*i +: 8];
      exp_wr.push_back({AW'(mptr), d});
      mregs[mptr] = d;
      mptr = (mptr + 1) % NR;
      write_byte(d, 1'b1);
    end
    bus_stop();
  endtask

  task automatic txn_read(input bit set, input logic [7:0] p, input int n);
    bus_start();
    if (set) begin
      write_byte({SA, 1'b0}, 1'b1);
      write_byte(p, 1'b1);
      mptr = int'(p);
      bus_start();
    end
    write_byte({SA, 1'b1}, 1'b1);
    for (int i = 0; i < n; i++) read_byte(i < n - 1);
    bus_stop();
  endtask

  task automatic chk_reg(input int idx, input logic [7:0] e);
    host_rd_addr = AW'(idx);
    #1;
    check($sformatf("host_rd_data[%0d]", idx), host_rd_data, e);
  endtask

  initial begin
    int c0, idx;
    logic s;
    fork monitor(); join_none
    reset = 0; scl_m = 1; sda_m = 1; host_rd_addr = '0;
    for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
    mptr = 0;
    repeat (3) @(negedge clk);
    check("reset sda_oe", sda_oe, 0);
    check("reset busy", busy, 0);
    check("reset wr_strobe", wr_strobe, 0);
    check("reset wr_addr/wr_data", {wr_addr, wr_data}, 0);
    chk_reg(0, 8'h00);
    chk_reg(15, 8'h00);
    reset = 1;
    repeat (4) @(negedge clk);

    // Basic write: registers 3 and 4
    txn_write(SA, 8'h03, 2, 32'h5AA5);
    chk_reg(4, 8'h5A);
    chk_reg(3, 8'hA5);
    check("busy after write", busy, 0);

    // Repeated-start read of two bytes
    txn_read(1, 8'h03, 2);
    check("busy after read", busy, 0);

    // Wrong address: no ACK, SDA never pulled
    c0 = oe_cnt;
    txn_write(7'h48, 8'h00, 0, 0);
    check("wrong addr sda_oe cycles", oe_cnt - c0, 0);

    // Pointer wrap, then out-of-range pointer leaves pointer alone
    txn_write(SA, 8'h0F, 2, 32'h2211);
    chk_reg(15, 8'h11);
    chk_reg(0, 8'h22);
    txn_write(SA, 8'h10, 0, 0);
    txn_read(0, 8'h00, 1);

    // STOP after four data bits: nothing is written
    bus_start();
    write_byte({SA, 1'b0}, 1'b1);
    write_byte(8'h06, 1'b1);
    mptr = 6;
    for (int i = 0; i < 4; i++) bus_bit(1'b1, s);
    bus_stop();
    check("busy after partial byte", busy, 0);
    check("sda_oe after partial byte", sda_oe, 0);
    chk_reg(6, mregs[6]);

    // Reset while the slave is driving a read bit
    txn_write(SA, 8'h02, 1, 32'h3C);
    bus_start();
    write_byte({SA, 1'b0}, 1'b1);
    write_byte(8'h02, 1'b1);
    mptr = 2;
    bus_start();
    write_byte({SA, 1'b1}, 1'b1);
    check("sda_oe driving read MSB", sda_oe, 1);
    @(posedge clk); #2 reset = 0;
    #1 check("sda_oe async on reset", sda_oe, 0);
    for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
    mptr = 0;
    scl_m = 1; sda_m = 1;
    repeat (4) @(negedge clk);
    reset = 1;
    repeat (4) @(negedge clk);
    chk_reg(2, 8'h00);
    txn_write(SA, 8'h05, 2, 32'hC3E7);
    chk_reg(5, 8'hE7);
    chk_reg(6, 8'hC3);

    // Randomised traffic against the model
    for (int t = 0; t < 20; t++) begin
      case ($urandom_range(0, 3))
        0, 1: txn_write(($urandom_range(0, 5) == 0) ? 7'($urandom) : SA,
                        8'($urandom_range(0, 17)), $urandom_range(1, 4), $urandom);
        2:    txn_read(1, 8'($urandom_range(0, NR - 1)), $urandom_range(1, 3));
        default: txn_read(0, 8'h00, $urandom_range(1, 2));
      endcase
      idx = $urandom_range(0, NR - 1);
      chk_reg(idx, mregs[idx]);
      check("busy idle", busy, 0);
    end

    repeat (20) @(negedge clk);
    check("pending bus responses", exp_bus.size(), 0);
    check("pending writes", exp_wr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
